// File: rtl/stdp_weight_updater.sv
// Single writer of all synaptic weights: buffers per-synapse STDP delta requests, merges repeats,
// arbitrates round-robin and applies one saturating read-modify-write per cycle over two stages.
module stdp_weight_updater #(
  parameter int unsigned N_SYN  = 4,
  parameter int unsigned DW     = 16,
  parameter int          W_MIN  = 0,
  parameter int          W_MAX  = 2 ** (DW - 1) - 1,
  parameter int          W_INIT = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_SYN-1:0]               change_weight_i,
  input  logic [N_SYN-1:0][DW-1:0]       delta_w_i,
  input  logic                           init_valid_i,
  input  logic [$clog2(N_SYN)-1:0]       init_addr_i,
  input  logic [DW-1:0]                  init_value_i,
  output logic [N_SYN-1:0][DW-1:0]       weight_o,
  output logic                           busy_o,
  output logic                           sat_event_o,
  output logic                           merge_event_o
);

  localparam int unsigned AW = $clog2(N_SYN);
  localparam logic signed [DW:0] WMinX   = (DW + 1)'(W_MIN);
  localparam logic signed [DW:0] WMaxX   = (DW + 1)'(W_MAX);
  localparam logic [DW-1:0]      WInit   = DW'(W_INIT);
  localparam logic [AW-1:0]      LastIdx = AW'(N_SYN - 1);

  // Pending slots, one per synapse
  logic [N_SYN-1:0]           valid_q, valid_d;
  logic [N_SYN-1:0][DW-1:0]   pdelta_q, pdelta_d;
  logic [AW-1:0]              ptr_q, ptr_d;

  // Stage 1 registers; stage 2 is the combinational read-modify-write feeding weight_q
  logic                       s1_valid_q;
  logic [AW-1:0]              s1_idx_q;
  logic [DW-1:0]              s1_delta_q;

  logic [N_SYN-1:0][DW-1:0]   weight_q, weight_d;
  logic                       sat_q, sat_d;
  logic                       merge_q, merge_d;

  logic                       gnt_valid;
  logic [AW-1:0]              gnt_idx;
  logic [DW-1:0]              s2_cur;
  logic signed [DW:0]         s2_sum;
  logic [DW-1:0]              s2_res;
  logic                       s2_clamped;
  logic                       s2_blocked;

  function automatic logic [AW-1:0] rr_idx(input logic [AW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_SYN) s = s - N_SYN;
    return AW'(s);
  endfunction

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1]) begin
      return s[DW] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    end
    return s[DW-1:0];
  endfunction

  // Round-robin: first occupied slot at or after the pointer
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_SYN; k++) begin
      if (!gnt_valid && valid_q[rr_idx(ptr_q, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + AW'(1);
    end
  end

  // A slot freed by a grant or host load this cycle takes a new request as a fresh capture
  always_comb begin
    valid_d  = valid_q;
    pdelta_d = pdelta_q;
    merge_d  = 1'b0;
    for (int unsigned i = 0; i < N_SYN; i++) begin
      if ((gnt_valid && gnt_idx == AW'(i)) || (init_valid_i && init_addr_i == AW'(i))) begin
        valid_d[i] = 1'b0;
      end
      if (change_weight_i[i]) begin
        if (valid_d[i]) begin
          pdelta_d[i] = sat_add(pdelta_q[i], delta_w_i[i]);
          merge_d     = 1'b1;
        end else begin
          pdelta_d[i] = delta_w_i[i];
          valid_d[i]  = 1'b1;
        end
      end
    end
  end

  // Stage 2 reads the live register, so back-to-back updates to one synapse need no bypass
  always_comb begin
    s2_cur     = weight_q[s1_idx_q];
    s2_sum     = $signed({s2_cur[DW-1], s2_cur}) + $signed({s1_delta_q[DW-1], s1_delta_q});
    s2_res     = s2_sum[DW-1:0];
    s2_clamped = 1'b0;
    if (s2_sum < WMinX) begin
      s2_res     = WMinX[DW-1:0];
      s2_clamped = 1'b1;
    end else if (s2_sum > WMaxX) begin
      s2_res     = WMaxX[DW-1:0];
      s2_clamped = 1'b1;
    end
  end

  assign s2_blocked = init_valid_i && (init_addr_i == s1_idx_q);

  always_comb begin
    weight_d = weight_q;
    sat_d    = 1'b0;
    if (s1_valid_q && !s2_blocked) begin
      weight_d[s1_idx_q] = s2_res;
      sat_d              = s2_clamped;
    end
    if (init_valid_i && 32'(init_addr_i) < N_SYN) begin
      weight_d[init_addr_i] = init_value_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      pdelta_q   <= '0;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_delta_q <= '0;
      weight_q   <= {N_SYN{WInit}};
      sat_q      <= 1'b0;
      merge_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pdelta_q   <= pdelta_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_valid;
      s1_idx_q   <= gnt_idx;
      s1_delta_q <= pdelta_q[gnt_idx];
      weight_q   <= weight_d;
      sat_q      <= sat_d;
      merge_q    <= merge_d;
    end
  end

  assign weight_o      = weight_q;
  assign busy_o        = (|valid_q) | s1_valid_q;
  assign sat_event_o   = sat_q;
  assign merge_event_o = merge_q;

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Bench for stdp_weight_updater: directed scenarios with literal expectations plus a long random
// run, all outputs compared every cycle against a behavioural request-queue model.
module tb_stdp_weight_updater;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 16;
  localparam int          WMIN  = 0;
  localparam int          WMAX  = 32767;
  localparam int          WINIT = 0;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           change_weight_i;
  logic [N-1:0][DW-1:0]   delta_w_i;
  logic                   init_valid_i;
  logic [1:0]             init_addr_i;
  logic [DW-1:0]          init_value_i;
  logic [N-1:0][DW-1:0]   weight_o;
  logic                   busy_o;
  logic                   sat_event_o;
  logic                   merge_event_o;

  stdp_weight_updater #(
    .N_SYN (N),
    .DW    (DW),
    .W_MIN (WMIN),
    .W_MAX (WMAX),
    .W_INIT(WINIT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .change_weight_i(change_weight_i),
    .delta_w_i      (delta_w_i),
    .init_valid_i   (init_valid_i),
    .init_addr_i    (init_addr_i),
    .init_value_i   (init_value_i),
    .weight_o       (weight_o),
    .busy_o         (busy_o),
    .sat_event_o    (sat_event_o),
    .merge_event_o  (merge_event_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Reference model: weights, pending requests, pointer, one in-flight update
  int m_w[N];
  bit m_pv[N];
  int m_pd[N];
  int m_ptr;
  bit m_s1v;
  int m_s1i;
  int m_s1d;
  bit m_sat;
  bit m_merge;

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic bit m_busy();
    bit b;
    b = m_s1v;
    for (int i = 0; i < N; i++) b = b | m_pv[i];
    return b;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i]  = WINIT;
      m_pv[i] = 1'b0;
      m_pd[i] = 0;
    end
    m_ptr   = 0;
    m_s1v   = 1'b0;
    m_s1i   = 0;
    m_s1d   = 0;
    m_sat   = 1'b0;
    m_merge = 1'b0;
  endtask

  task automatic m_step();
    int g;
    int sum;
    int res;
    int a;
    bit nsat;
    bit nmerge;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && m_pv[j]) g = j;
    end
    nsat = 1'b0;
    if (m_s1v) begin
      sum = m_w[m_s1i] + m_s1d;
      res = (sum < WMIN) ? WMIN : ((sum > WMAX) ? WMAX : sum);
      if (!(init_valid_i && int'(init_addr_i) == m_s1i)) begin
        m_w[m_s1i] = res;
        nsat = (res != sum);
      end
    end
    if (init_valid_i) m_w[init_addr_i] = sx(init_value_i);
    m_s1v = (g >= 0);
    if (g >= 0) begin
      m_s1i   = g;
      m_s1d   = m_pd[g];
      m_pv[g] = 1'b0;
      m_ptr   = (g + 1) % N;
    end
    if (init_valid_i) m_pv[init_addr_i] = 1'b0;
    nmerge = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (change_weight_i[i]) begin
        if (m_pv[i]) begin
          a = m_pd[i] + sx(delta_w_i[i]);
          if (a > 32767) a = 32767;
          if (a < -32768) a = -32768;
          m_pd[i] = a;
          nmerge = 1'b1;
        end else begin
          m_pd[i] = sx(delta_w_i[i]);
          m_pv[i] = 1'b1;
        end
      end
    end
    m_sat   = nsat;
    m_merge = nmerge;
  endtask

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) m_reset();
      else m_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (%h) expected %0d", name, $signed(act), act, $signed(exp));
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk_i);
      if (check_en) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("model weight[%0d]", i), 32'($signed(weight_o[i])), m_w[i]);
        end
        chk("model busy", 32'(busy_o), 32'(m_busy()));
        chk("model sat_event", 32'(sat_event_o), 32'(m_sat));
        chk("model merge_event", 32'(merge_event_o), 32'(m_merge));
      end
    end
  end

  task automatic clear_inputs();
    change_weight_i = '0;
    for (int i = 0; i < N; i++) delta_w_i[i] = DW'($urandom);
    init_valid_i = 1'b0;
    init_addr_i  = 2'($urandom);
    init_value_i = DW'($urandom);
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after 40 cycles", name);
    end
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'($signed(weight_o[i]));
  endfunction

  function automatic logic [DW-1:0] rand_delta();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return DW'($urandom_range(0, 400) - 200);
    if (r < 90) return DW'($urandom);
    return (r < 95) ? 16'h7fff : 16'h8000;
  endfunction

  function automatic logic [DW-1:0] rand_value();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return DW'($urandom_range(0, 32767));
    if (r < 80) return DW'($urandom);
    return (r < 90) ? DW'($urandom_range(32700, 32767)) : DW'($urandom_range(0, 60));
  endfunction

  initial begin
    int rate;
    rst_ni = 1'b0;
    clear_inputs();
    m_reset();
    tick();
    tick();
    check_en = 1'b1;
    chk("reset busy", 32'(busy_o), 0);
    chk("reset weight[2]", w(2), WINIT);
    rst_ni = 1'b1;
    tick();

    // Single request: slot, S1, then write two edges after the pulse
    change_weight_i = 4'b0100;
    delta_w_i[2] = 16'd100;
    tick();
    clear_inputs();
    chk("single busy edge k", 32'(busy_o), 1);
    chk("single weight[2] edge k", w(2), 0);
    tick();
    chk("single busy edge k+1", 32'(busy_o), 1);
    chk("single weight[2] edge k+1", w(2), 0);
    tick();
    chk("single weight[2] edge k+2", w(2), 100);
    chk("single busy after write", 32'(busy_o), 0);

    // Merge: slot 0 wins arbitration while slot 1 accumulates 30+20
    change_weight_i = 4'b0011;
    delta_w_i[0] = 16'd7;
    delta_w_i[1] = 16'd30;
    tick();
    change_weight_i = 4'b0011;
    delta_w_i[0] = 16'd5;
    delta_w_i[1] = 16'd20;
    tick();
    clear_inputs();
    chk("merge pulse", 32'(merge_event_o), 1);
    tick();
    chk("merge pulse width", 32'(merge_event_o), 0);
    wait_idle("merge drain");
    chk("merge weight[1]", w(1), 50);
    chk("merge weight[0]", w(0), 12);

    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post-reset weight[1]", w(1), WINIT);

    // Round-robin from pointer 0; the pointer wraps so the second burst repeats the order
    for (int b = 1; b <= 2; b++) begin
      change_weight_i = 4'b1111;
      for (int i = 0; i < N; i++) delta_w_i[i] = 16'd1;
      tick();
      clear_inputs();
      tick();
      for (int j = 0; j < N; j++) begin
        tick();
        for (int m = 0; m < N; m++) begin
          chk($sformatf("rr burst%0d step%0d weight[%0d]", b, j, m), w(m), (m <= j) ? b : b - 1);
        end
      end
      wait_idle("rr drain");
    end

    // Saturation at W_MAX and W_MIN
    init_valid_i = 1'b1;
    init_addr_i  = 2'd3;
    init_value_i = 16'(WMAX - 5);
    tick();
    clear_inputs();
    change_weight_i = 4'b1000;
    delta_w_i[3] = 16'd10;
    tick();
    clear_inputs();
    tick();
    tick();
    chk("sat high weight[3]", w(3), WMAX);
    chk("sat high pulse", 32'(sat_event_o), 1);
    tick();
    chk("sat high pulse width", 32'(sat_event_o), 0);
    init_valid_i = 1'b1;
    init_addr_i  = 2'd3;
    init_value_i = 16'(WMIN + 3);
    tick();
    clear_inputs();
    change_weight_i = 4'b1000;
    delta_w_i[3] = 16'hffce;
    tick();
    clear_inputs();
    tick();
    tick();
    chk("sat low weight[3]", w(3), WMIN);
    chk("sat low pulse", 32'(sat_event_o), 1);

    // Host load collides with the S2 write to synapse 0
    tick();
    change_weight_i = 4'b0001;
    delta_w_i[0] = 16'd40;
    tick();
    clear_inputs();
    tick();
    init_valid_i = 1'b1;
    init_addr_i  = 2'd0;
    init_value_i = 16'd500;
    tick();
    clear_inputs();
    chk("collision weight[0]", w(0), 500);
    chk("collision no sat", 32'(sat_event_o), 0);
    wait_idle("collision drain");
    chk("collision weight[0] held", w(0), 500);

    // Host load clears a slot still waiting behind the pointer
    change_weight_i = 4'b1111;
    for (int i = 0; i < N; i++) delta_w_i[i] = 16'd1;
    tick();
    clear_inputs();
    tick();
    init_valid_i = 1'b1;
    init_addr_i  = 2'd0;
    init_value_i = 16'd500;
    tick();
    clear_inputs();
    wait_idle("slot clear drain");
    chk("slot clear weight[0]", w(0), 500);
    chk("slot clear weight[3]", w(3), 1);

    // Asynchronous reset with three slots occupied
    init_valid_i = 1'b1;
    init_addr_i  = 2'd1;
    init_value_i = 16'd1234;
    tick();
    clear_inputs();
    change_weight_i = 4'b0111;
    for (int i = 0; i < N; i++) delta_w_i[i] = 16'd1;
    tick();
    clear_inputs();
    #2;
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("async reset weight[%0d]", i), w(i), WINIT);
    chk("async reset busy", 32'(busy_o), 0);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < N; i++) chk($sformatf("post release weight[%0d]", i), w(i), WINIT);
      chk("post release busy", 32'(busy_o), 0);
    end

    // Random traffic with alternating request density and one mid-run reset
    for (int c = 0; c < 2000; c++) begin
      rate = ((c / 250) % 2 == 1) ? 90 : 30;
      for (int i = 0; i < N; i++) begin
        change_weight_i[i] = ($urandom_range(0, 99) < rate);
        delta_w_i[i] = rand_delta();
      end
      init_valid_i = ($urandom_range(0, 99) < 6);
      init_addr_i  = 2'($urandom_range(0, N - 1));
      init_value_i = rand_value();
      if (c == 1200) begin
        #3;
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
      end
      tick();
    end
    clear_inputs();
    wait_idle("final drain");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
